// File: rtl/acc_kernel_launcher.sv
// acc_kernel_launcher: ap_ctrl_chain initiator that runs a batch of kernel launches with bounded outstanding runs; optional watchdog via ACC_LAUNCHER_WDT_EN
module acc_kernel_launcher #(
  parameter int CNT_W      = 16,
  parameter int MAX_OUT    = 2,
  parameter int WDT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_start,
  input  logic [CNT_W-1:0] cmd_num_runs,
  output logic             cmd_busy,
  output logic             cmd_done,
  output logic             cmd_err,
  output logic [CNT_W-1:0] runs_done,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_num, r_issued, r_completed, w_out;
  logic r_err, w_run, w_acc, w_cmp, w_spur, w_launch, w_wdt_hit, w_unused;
  assign w_unused    = ap_idle;
  assign w_run       = r_state == ISSUE || r_state == DRAIN;
  assign w_out       = r_issued - r_completed;
  assign ap_start    = r_state == ISSUE && r_issued < r_num && w_out < CNT_W'(MAX_OUT);
  assign ap_continue = ap_done && w_run && r_issued != r_completed;
  assign w_acc       = ap_start && ap_ready;
  assign w_cmp       = ap_continue;
  assign w_spur      = ap_done && !ap_continue && r_state != IDLE;
  assign w_launch    = r_state == IDLE && cmd_start;
  assign cmd_busy    = r_state != IDLE;
  assign cmd_done    = r_state == DONE;
  assign cmd_err     = r_err;
  assign runs_done   = r_completed;
`ifdef ACC_LAUNCHER_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] r_wdt;
  logic w_stall;
  assign w_stall   = w_run && !w_acc && !w_cmp;
  assign w_wdt_hit = w_stall && r_wdt == WDT_W'(WDT_CYCLES - 1);
  // Watchdog counts consecutive cycles without kernel progress while a batch runs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wdt <= '0;
    else        r_wdt <= w_stall ? r_wdt + 1'b1 : '0;
`else
  localparam int unused_wdt = WDT_CYCLES;
  assign w_wdt_hit = 1'b0;
`endif
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // Next state: launch, issue until all accepted, drain until all done, one-cycle done
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (cmd_start) w_next = cmd_num_runs == '0 ? DONE : ISSUE;
      ISSUE:   if (r_issued == r_num) w_next = DRAIN;
      DRAIN:   if (r_completed == r_num) w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (w_wdt_hit) w_next = DONE;
  end
  // Batch counters and sticky error; a launch reloads everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_num       <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_err       <= 1'b0;
    end else if (w_launch) begin
      r_num       <= cmd_num_runs;
      r_issued    <= '0;
      r_completed <= '0;
      r_err       <= 1'b0;
    end else begin
      r_issued    <= r_issued + CNT_W'(w_acc);
      r_completed <= r_completed + CNT_W'(w_cmp);
      if (w_spur || w_wdt_hit) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_acc_kernel_launcher.sv
// tb_acc_kernel_launcher: directed bench for acc_kernel_launcher (MAX_OUT=2, WDT_CYCLES=50)
module tb_acc_kernel_launcher;
  logic        clk = 1'b0;
  logic        rst_n, cmd_start, ap_ready, ap_done, ap_idle;
  logic [15:0] cmd_num_runs, runs_done;
  logic        cmd_busy, cmd_done, cmd_err, ap_start, ap_continue;
  int checks = 0;
  int failures = 0;
  int n;

  acc_kernel_launcher #(.CNT_W(16), .MAX_OUT(2), .WDT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_num_runs(cmd_num_runs),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .runs_done(runs_done),
    .ap_start(ap_start), .ap_continue(ap_continue), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_start = 1'b0; cmd_num_runs = '0;
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    tick; tick;
    chk("rst_busy", cmd_busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_runs", runs_done, 0);
    chk("rst_start", ap_start, 0);
    chk("rst_cont", ap_continue, 0);
    rst_n = 1'b1;
    tick;
    // zero-run batch goes straight to DONE
    cmd_start = 1'b1; cmd_num_runs = 16'd0; tick; cmd_start = 1'b0;
    chk("zero_done", cmd_done, 1);
    chk("zero_busy", cmd_busy, 1);
    chk("zero_start", ap_start, 0);
    chk("zero_runs", runs_done, 0);
    tick;
    chk("zero_done_clr", cmd_done, 0);
    chk("zero_idle", cmd_busy, 0);
    // num=2, start held until accepted, cmd_start while busy ignored
    cmd_start = 1'b1; cmd_num_runs = 16'd2; tick; cmd_start = 1'b0;
    chk("b2_start", ap_start, 1);
    cmd_start = 1'b1; cmd_num_runs = 16'd5; tick; cmd_start = 1'b0;
    chk("b2_hold", ap_start, 1);
    ap_ready = 1'b1; tick;
    chk("b2_start2", ap_start, 1);
    tick; ap_ready = 1'b0;
    chk("b2_all_issued", ap_start, 0);
    tick;
    chk("b2_no_cont", ap_continue, 0);
    ap_done = 1'b1; #1;
    chk("b2_cont", ap_continue, 1);
    tick; ap_done = 1'b0;
    chk("b2_runs1", runs_done, 1);
    ap_done = 1'b1; tick; ap_done = 1'b0;
    chk("b2_runs2", runs_done, 2);
    chk("b2_not_yet", cmd_done, 0);
    tick;
    chk("b2_done", cmd_done, 1);
    chk("b2_err", cmd_err, 0);
    tick;
    chk("b2_idle", cmd_busy, 0);
    chk("b2_runs_kept", runs_done, 2);
    // num=4 with ap_ready held: outstanding limit and simultaneous accept+done
    ap_ready = 1'b1; cmd_start = 1'b1; cmd_num_runs = 16'd4; tick; cmd_start = 1'b0;
    chk("b4_start", ap_start, 1);
    tick; tick;
    chk("b4_limit", ap_start, 0);
    tick;
    chk("b4_limit_hold", ap_start, 0);
    ap_done = 1'b1; #1;
    chk("b4_cont", ap_continue, 1);
    tick; ap_done = 1'b0;
    chk("b4_rise", ap_start, 1);
    chk("b4_runs1", runs_done, 1);
    ap_done = 1'b1; tick; ap_done = 1'b0;
    chk("b4_both_runs", runs_done, 2);
    chk("b4_both_start", ap_start, 1);
    tick;
    chk("b4_all_issued", ap_start, 0);
    ap_ready = 1'b0;
    tick;
    ap_done = 1'b1; tick; tick; ap_done = 1'b0;
    chk("b4_runs4", runs_done, 4);
    chk("b4_not_yet", cmd_done, 0);
    tick;
    chk("b4_done", cmd_done, 1);
    chk("b4_err", cmd_err, 0);
    tick;
    // spurious done in IDLE and with nothing outstanding
    ap_done = 1'b1; #1;
    chk("sp_idle_cont", ap_continue, 0);
    tick; ap_done = 1'b0;
    chk("sp_idle_err", cmd_err, 0);
    cmd_start = 1'b1; cmd_num_runs = 16'd1; tick; cmd_start = 1'b0;
    ap_done = 1'b1; #1;
    chk("sp_run_cont", ap_continue, 0);
    tick; ap_done = 1'b0;
    chk("sp_run_err", cmd_err, 1);
    chk("sp_run_runs", runs_done, 0);
    ap_ready = 1'b1; tick; ap_ready = 1'b0;
    tick;
    ap_done = 1'b1; #1;
    chk("sp_real_cont", ap_continue, 1);
    tick; ap_done = 1'b0;
    chk("sp_runs1", runs_done, 1);
    tick;
    chk("sp_done", cmd_done, 1);
    chk("sp_err_done", cmd_err, 1);
    tick;
    chk("sp_err_sticky", cmd_err, 1);
    cmd_start = 1'b1; cmd_num_runs = 16'd0; tick; cmd_start = 1'b0;
    chk("sp_err_clear", cmd_err, 0);
    chk("sp_clr_done", cmd_done, 1);
    tick;
    // hung kernel: accepted run never completes
    ap_ready = 1'b1; cmd_start = 1'b1; cmd_num_runs = 16'd1; tick; cmd_start = 1'b0;
    tick; ap_ready = 1'b0;
`ifdef ACC_LAUNCHER_WDT_EN
    n = 0;
    while (!cmd_done && n < 200) begin
      tick;
      n++;
    end
    chk("wdt_cycles", n, 50);
    chk("wdt_err", cmd_err, 1);
    chk("wdt_runs", runs_done, 0);
    chk("wdt_start", ap_start, 0);
`else
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      tick;
      if (cmd_busy) n++;
    end
    chk("hang_busy", n, 1000);
    chk("hang_start", ap_start, 0);
    chk("hang_err", cmd_err, 0);
`endif
    rst_n = 1'b0; #1;
    chk("async_rst_busy", cmd_busy, 0);
    chk("async_rst_start", ap_start, 0);
    rst_n = 1'b1;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
